// File: rtl/tick_bcd_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tick_bcd_counter                                              |
// | Summary  : Turns clk_div rising edges into one-cycle ticks that step a   |
// |            multi-digit BCD up/down counter with load, enable and         |
// |            terminal-count reporting. Optional display scan: SEG7_SCAN_EN.|
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tick_bcd_counter #(
    parameter int DIGITS    = 4,
    parameter int MAX_COUNT = 9999,
    parameter int SCAN_DIV  = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clk_div,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  tick,
    output logic                  tc,
    output logic                  err
`ifdef SEG7_SCAN_EN
    ,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an
`endif
);

    function automatic logic [4*DIGITS-1:0] f_to_bcd(input int value);
        logic [4*DIGITS-1:0] result;
        int                  rem;
        result = '0;
        rem    = value;
        for (int i = 0; i < DIGITS; i++) begin
            result[4*i +: 4] = 4'(rem % 10);
            rem              = rem / 10;
        end
        return result;
    endfunction

    localparam logic [4*DIGITS-1:0] c_MAX_BCD = f_to_bcd(MAX_COUNT);

    if (MAX_COUNT < 0 || MAX_COUNT >= 10**DIGITS || SCAN_DIV < 1) begin : g_param_check
        $error("tick_bcd_counter: MAX_COUNT must fit in DIGITS and SCAN_DIV must be >= 1");
    end

    logic                 r_clk_div_q;
    logic                 r_tick;
    logic                 r_tc;
    logic                 r_err;
    logic [4*DIGITS-1:0]  r_bcd;

    logic                 w_edge;
    logic                 w_at_max;
    logic                 w_at_zero;
    logic                 w_load_ok;
    logic [4*DIGITS-1:0]  w_inc;
    logic [4*DIGITS-1:0]  w_dec;
    logic [DIGITS-1:0]    w_inc_c;
    logic [DIGITS-1:0]    w_dec_b;
    logic [DIGITS-1:0]    w_ld_digit_ok;

    // clk_div is produced in the clk domain, so a plain delayed copy is enough.
    assign w_edge    = clk_div & ~r_clk_div_q;
    assign w_at_max  = (r_bcd == c_MAX_BCD);
    assign w_at_zero = (r_bcd == '0);

    // Nibble-wise compare equals numeric compare once every digit is 0..9.
    assign w_load_ok = (&w_ld_digit_ok) && (load_val <= c_MAX_BCD);

    assign w_inc_c[0] = 1'b1;
    assign w_dec_b[0] = 1'b1;

    for (genvar d = 0; d < DIGITS; d++) begin : g_digit
        logic [3:0] w_dig;
        logic       w_nine;
        logic       w_zero;

        assign w_dig  = r_bcd[4*d +: 4];
        assign w_nine = (w_dig == 4'd9);
        assign w_zero = (w_dig == 4'd0);

        assign w_inc[4*d +: 4] = !w_inc_c[d] ? w_dig : (w_nine ? 4'd0 : w_dig + 4'd1);
        assign w_dec[4*d +: 4] = !w_dec_b[d] ? w_dig : (w_zero ? 4'd9 : w_dig - 4'd1);

        assign w_ld_digit_ok[d] = (load_val[4*d +: 4] <= 4'd9);

        if (d < DIGITS - 1) begin : g_ripple
            assign w_inc_c[d+1] = w_inc_c[d] & w_nine;
            assign w_dec_b[d+1] = w_dec_b[d] & w_zero;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // A high clk_div at reset release must not look like a fresh edge.
            r_clk_div_q <= 1'b1;
            r_tick      <= 1'b0;
            r_tc        <= 1'b0;
            r_err       <= 1'b0;
            r_bcd       <= '0;
        end else begin
            r_clk_div_q <= clk_div;
            r_tick      <= w_edge;
            r_tc        <= 1'b0;
            if (load) begin
                if (w_load_ok) begin
                    r_bcd <= load_val;
                end else begin
                    r_err <= 1'b1;
                end
            end else if (w_edge && en) begin
                if (up) begin
                    if (w_at_max) begin
                        r_bcd <= '0;
                        r_tc  <= 1'b1;
                    end else begin
                        r_bcd <= w_inc;
                    end
                end else begin
                    if (w_at_zero) begin
                        r_bcd <= c_MAX_BCD;
                        r_tc  <= 1'b1;
                    end else begin
                        r_bcd <= w_dec;
                    end
                end
            end
        end
    end

    assign bcd  = r_bcd;
    assign tick = r_tick;
    assign tc   = r_tc;
    assign err  = r_err;

`ifdef SEG7_SCAN_EN
    localparam int                  c_SCAN_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int                  c_IDX_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [c_SCAN_W-1:0] c_SCAN_LAST = c_SCAN_W'(SCAN_DIV - 1);
    localparam logic [c_IDX_W-1:0]  c_IDX_LAST  = c_IDX_W'(DIGITS - 1);

    logic [c_SCAN_W-1:0] r_scan_cnt;
    logic [c_IDX_W-1:0]  r_scan_idx;
    logic [3:0]          w_sel_digit;
    logic [DIGITS-1:0]   w_an;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_scan_cnt <= '0;
            r_scan_idx <= '0;
        end else if (r_scan_cnt == c_SCAN_LAST) begin
            r_scan_cnt <= '0;
            r_scan_idx <= (r_scan_idx == c_IDX_LAST) ? '0 : r_scan_idx + 1'b1;
        end else begin
            r_scan_cnt <= r_scan_cnt + 1'b1;
        end
    end

    always_comb begin
        w_sel_digit = 4'd0;
        w_an        = '1;
        for (int d = 0; d < DIGITS; d++) begin
            if (r_scan_idx == c_IDX_W'(d)) begin
                w_sel_digit = r_bcd[4*d +: 4];
                w_an[d]     = 1'b0;
            end
        end
    end

    // Segment order {g,f,e,d,c,b,a}, active-low; non-BCD blanks the digit.
    always_comb begin
        seg = 7'b111_1111;
        case (w_sel_digit)
            4'd0:    seg = 7'b100_0000;
            4'd1:    seg = 7'b111_1001;
            4'd2:    seg = 7'b010_0100;
            4'd3:    seg = 7'b011_0000;
            4'd4:    seg = 7'b001_1001;
            4'd5:    seg = 7'b001_0010;
            4'd6:    seg = 7'b000_0010;
            4'd7:    seg = 7'b111_1000;
            4'd8:    seg = 7'b000_0000;
            4'd9:    seg = 7'b001_0000;
            default: seg = 7'b111_1111;
        endcase
    end

    assign an = w_an;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tick_bcd_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_tick_bcd_counter                                           |
// | Summary  : Scoreboard bench for tick_bcd_counter (DIGITS=2, MAX=59).     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_tick_bcd_counter;

    localparam int c_DIGITS = 2;
    localparam int c_MAX    = 59;
    localparam int c_SCAN   = 4;

    logic       clk;
    logic       rst;
    logic       clk_div;
    logic       en;
    logic       up;
    logic       load;
    logic [7:0] load_val;
    logic [7:0] bcd;
    logic       tick;
    logic       tc;
    logic       err;
`ifdef SEG7_SCAN_EN
    logic [6:0] seg;
    logic [1:0] an;
`endif

    tick_bcd_counter #(
        .DIGITS    (c_DIGITS),
        .MAX_COUNT (c_MAX),
        .SCAN_DIV  (c_SCAN)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .clk_div  (clk_div),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .bcd      (bcd),
        .tick     (tick),
        .tc       (tc),
        .err      (err)
`ifdef SEG7_SCAN_EN
        ,
        .seg      (seg),
        .an       (an)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] bcd;
        logic       tick;
        logic       tc;
        logic       err;
        logic [6:0] seg;
        logic [1:0] an;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int n_ticks  = 0;
    logic edge_tc;
    logic edge_tick;

    // Reference model state, kept in plain decimal.
    int   m_cnt   = 0;
    logic m_err   = 1'b0;
    logic m_q     = 1'b1;
    int   m_scnt  = 0;
    int   m_sidx  = 0;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_checks++;
        if (obs !== req) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h required 0x%0h at %0t", tag, obs, req, $time);
        end
    endtask

    function automatic logic [7:0] f_bcd(input int value);
        logic [3:0] tens;
        logic [3:0] ones;
        tens = 4'(value / 10);
        ones = 4'(value % 10);
        return {tens, ones};
    endfunction

    function automatic logic [6:0] f_seg(input logic [3:0] dig);
        case (dig)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic model_next(output exp_t e);
        logic       edge_seen;
        logic [3:0] hi;
        logic [3:0] lo;
        logic [7:0] shown;
        e = '0;
        if (rst) begin
            m_cnt  = 0;
            m_err  = 1'b0;
            m_q    = 1'b1;
            m_scnt = 0;
            m_sidx = 0;
        end else begin
            edge_seen = clk_div && !m_q;
            m_q       = clk_div;
            e.tick    = edge_seen;
            if (load) begin
                hi = load_val[7:4];
                lo = load_val[3:0];
                if (hi <= 9 && lo <= 9 && (int'(hi) * 10 + int'(lo)) <= c_MAX)
                    m_cnt = int'(hi) * 10 + int'(lo);
                else
                    m_err = 1'b1;
            end else if (edge_seen && en) begin
                if (up) begin
                    if (m_cnt == c_MAX) begin m_cnt = 0; e.tc = 1'b1; end
                    else m_cnt = m_cnt + 1;
                end else begin
                    if (m_cnt == 0) begin m_cnt = c_MAX; e.tc = 1'b1; end
                    else m_cnt = m_cnt - 1;
                end
            end
            if (m_scnt == c_SCAN - 1) begin
                m_scnt = 0;
                m_sidx = (m_sidx + 1) % c_DIGITS;
            end else begin
                m_scnt = m_scnt + 1;
            end
        end
        e.bcd = f_bcd(m_cnt);
        e.err = m_err;
        shown = e.bcd;
        e.an  = (m_sidx == 0) ? 2'b10 : 2'b01;
        e.seg = f_seg((m_sidx == 0) ? shown[3:0] : shown[7:4]);
    endtask

    // Drive-side pushes the model's prediction; after the edge it is popped and compared.
    task automatic step();
        exp_t e;
        exp_t got;
        model_next(e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        check_value("bcd", 32'(bcd), 32'(got.bcd));
        check_value("tick", 32'(tick), 32'(got.tick));
        check_value("tc", 32'(tc), 32'(got.tc));
        check_value("err", 32'(err), 32'(got.err));
`ifdef SEG7_SCAN_EN
        check_value("an", 32'(an), 32'(got.an));
        check_value("seg", 32'(seg), 32'(got.seg));
        check_value("an_one_low", 32'($countones(~an)), 32'd1);
`endif
        if (tick === 1'b1) n_ticks++;
    endtask

    task automatic pulse();
        clk_div = 1'b0;
        step();
        clk_div = 1'b1;
        step();
        edge_tick = tick;
        edge_tc   = tc;
        step();
    endtask

    task automatic load_step(input logic [7:0] value);
        load     = 1'b1;
        load_val = value;
        step();
        load     = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clk_div = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = 8'h00;
        edge_tc = 1'b0; edge_tick = 1'b0;
        repeat (3) step();
        check_value("rst_bcd", 32'(bcd), 32'h00);
        check_value("rst_err", 32'(err), 32'h0);

        // clk_div high through reset release must not tick
        rst = 1'b0;
        n_ticks = 0;
        repeat (3) step();
        check_value("release_ticks", 32'(n_ticks), 32'd0);

        en = 1'b1; up = 1'b1;
        n_ticks = 0;
        pulse();
        check_value("first_ticks", 32'(n_ticks), 32'd1);
        check_value("first_bcd", 32'(bcd), 32'h01);

        load_step(8'h58);
        pulse();
        check_value("up_59_bcd", 32'(bcd), 32'h59);
        check_value("up_59_tc", 32'(edge_tc), 32'h0);
        pulse();
        check_value("up_wrap_bcd", 32'(bcd), 32'h00);
        check_value("up_wrap_tc", 32'(edge_tc), 32'h1);

        up = 1'b0;
        load_step(8'h10);
        pulse();
        check_value("borrow_bcd", 32'(bcd), 32'h09);
        check_value("borrow_tc", 32'(edge_tc), 32'h0);
        load_step(8'h00);
        pulse();
        check_value("down_wrap_bcd", 32'(bcd), 32'h59);
        check_value("down_wrap_tc", 32'(edge_tc), 32'h1);

        load_step(8'h6A);
        check_value("bad_digit_bcd", 32'(bcd), 32'h59);
        check_value("bad_digit_err", 32'(err), 32'h1);
        load_step(8'h60);
        check_value("over_max_bcd", 32'(bcd), 32'h59);
        check_value("over_max_err", 32'(err), 32'h1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_value("err_clear", 32'(err), 32'h0);
        check_value("err_clear_bcd", 32'(bcd), 32'h00);

        // load coinciding with an edge wins over counting
        up = 1'b1; en = 1'b1;
        clk_div = 1'b0; step();
        clk_div = 1'b1; load_step(8'h30);
        check_value("ld_edge_bcd", 32'(bcd), 32'h30);
        check_value("ld_edge_tick", 32'(tick), 32'h1);
        check_value("ld_edge_tc", 32'(tc), 32'h0);
        load_step(8'h59);
        clk_div = 1'b0; step();
        clk_div = 1'b1; load_step(8'h12);
        check_value("ld_at_max_bcd", 32'(bcd), 32'h12);
        check_value("ld_at_max_tc", 32'(tc), 32'h0);

        en = 1'b0;
        n_ticks = 0;
        repeat (3) pulse();
        check_value("en0_ticks", 32'(n_ticks), 32'd3);
        check_value("en0_bcd", 32'(bcd), 32'h12);

        // reset arriving with a rising edge discards it
        en = 1'b1;
        clk_div = 1'b0; step();
        clk_div = 1'b1; rst = 1'b1; step();
        check_value("rst_edge_tick", 32'(tick), 32'h0);
        rst = 1'b0; step();
        check_value("post_rst_tick", 32'(tick), 32'h0);

        en = 1'b0;
        load_step(8'h47);
        repeat (12) step();
        check_value("scan_bcd", 32'(bcd), 32'h47);

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(2) == 0) clk_div = ~clk_div;
            en   = ($urandom_range(3) != 0);
            up   = $urandom_range(1) != 0;
            load = ($urandom_range(15) == 0);
            rst  = ($urandom_range(99) == 0);
            if ($urandom_range(3) == 0) load_val = 8'($urandom_range(255));
            else load_val = {4'($urandom_range(5)), 4'($urandom_range(9))};
            step();
        end
        rst = 1'b0; load = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tick_bcd_counter.md
Name: tick_bcd_counter

Overview:
- Downstream consumer of the clkdiv stage in the FPGA counter design.
- Samples the divided clock `clk_div` in the `clk` domain and converts each rising edge into a one-cycle tick.
- Each tick advances a multi-digit BCD up/down counter with load, enable and terminal-count reporting.
- The BCD value feeds the display logic.

Parameters:
- DIGITS, 4: number of BCD digits; counter width is 4*DIGITS.
- MAX_COUNT, 9999: decimal wrap value; must be < 10^DIGITS.
- SCAN_DIV, 1024: clk cycles per display digit; used only when SEG7_SCAN_EN is defined.

Ports:
- clk  in  1  system clock; same clock that drives clkdiv.
- rst  in  1  synchronous, active-high reset.
- clk_div  in  1  divided clock level from clkdiv, synchronous to clk.
- en  in  1  count enable.
- up  in  1  direction: 1 = increment, 0 = decrement.
- load  in  1  synchronous load strobe.
- load_val  in  4*DIGITS  BCD value to load; digit 0 in [3:0].
- bcd  out  4*DIGITS  current count, BCD, digit 0 in [3:0].
- tick  out  1  one-cycle pulse per detected clk_div rising edge.
- tc  out  1  one-cycle terminal-count pulse on wrap.
- err  out  1  sticky flag: an invalid load was rejected.

Behaviour:
- Interface: one clock, `clk`. Reset `rst` is synchronous and active-high. No asynchronous logic.
- Reset values:
  - bcd = 0, tick = 0, tc = 0, err = 0.
  - Internal clk_div_q = 1, so a clk_div already high at reset release produces no tick. A 0 must be sampled first.
- Edge detect: edge = clk_div & ~clk_div_q. clk_div_q <= clk_div every cycle. No extra synchronizer, since clk_div is generated from clk.
- Latency: edge seen in cycle N -> tick = 1 in cycle N+1, with bcd/tc already updated in N+1. Tick width is exactly 1 cycle regardless of clk_div high time.
- Priority per cycle: rst > load > (edge & en) count > hold.
- Load:
  - Valid means every digit ≤ 9 and the value ≤ MAX_COUNT.
  - Valid: bcd <= load_val.
  - Invalid: bcd unchanged, err <= 1.
  - err is cleared only by rst.
- Load in the same cycle as an edge: the load takes effect and no count occurs. tick still pulses in N+1. tc = 0.
- Enable: en = 0 -> edges still produce tick, but bcd holds and tc = 0.
- Count up:
  - Digit 0 +1; a digit at 9 becomes 0 and carries into the next digit. Full ripple within one cycle.
  - At bcd == MAX_COUNT -> bcd <= 0, tc = 1.
- Count down:
  - Digit 0 -1; a digit at 0 becomes 9 and borrows from the next digit.
  - At bcd == 0 -> bcd <= MAX_COUNT, tc = 1.
- tc: asserted only on a wrap, for the single cycle coinciding with tick.
- Direction changes on `up`: take effect on the next counted edge. No state retained.
- Reset mid-operation: all state returns to reset values on the next clk edge. A pending edge is discarded, and clk_div_q = 1 blocks a false tick.
- bcd never holds a non-BCD digit or a value > MAX_COUNT.

Optional Feature:
- Macro: SEG7_SCAN_EN.
- Defined: adds ports `seg` (out, 7, active-low segments a..g) and `an` (out, DIGITS, active-low digit enable).
  - A scan counter advances the digit select every SCAN_DIV clk cycles, digit 0 first, wrapping after DIGITS-1.
  - Exactly one `an` bit is low at any time.
  - `seg` is the 0–9 decode of the selected digit; non-BCD input blanks the display (all segments 1).
  - Reset: scan index 0, an = ~1 (digit 0 on).
- Not defined: `seg`/`an` ports and the scan logic are absent. Counter behaviour is identical.

Test Plan:
- Bench parameters: DIGITS=2, MAX_COUNT=59.
- Reset/edge: hold clk_div=1 through rst, release -> no tick. Toggle clk_div 0 -> 1 -> single 1-cycle tick, bcd=0x01.
- Up wrap: load 0x58, en=1, up=1, two clk_div edges -> bcd 0x59 then 0x00. tc=1 only on the second tick.
- Down wrap/borrow: load 0x10, up=0, one edge -> 0x09. Load 0x00, one edge -> 0x59 with tc=1.
- Invalid load: load_val=0x6A -> bcd unchanged, err=1. Then load_val=0x60 (> 59) -> bcd unchanged, err stays 1. rst -> err=0, bcd=0.
- Conflicts: load 0x30 in the same cycle as an edge -> bcd=0x30, tick=1, tc=0. en=0 with 3 edges -> 3 ticks, bcd holds.
- SEG7_SCAN_EN, SCAN_DIV=4:
  - bcd=0x47 -> an cycles 10/01 every 4 clks.
  - seg = "7" (7'b1111000) then "4" (7'b0011001).
  - Exactly one an bit is low at all times.
